// File: rtl/moving_average_filter_mc.sv
// moving_average_filter_mc
// Multi-channel boxcar low-pass filter. Each channel is averaged over the last
// 2**LOG2_SAMPLES samples. One adder is shared across all channels. The running
// sums stay exact, and the average is taken with an arithmetic shift (floor).
//
// Handshake: a frame is accepted on any cycle where in_valid && in_ready. in_ready is
// high only in IDLE. A frame offered while in_ready is low is dropped, and it sets the
// sticky overrun flag. out_valid is a one-cycle strobe 2*CHANNELS+1 cycles after the
// accept cycle. out_data holds its value between strobes.
module moving_average_filter_mc #(
    parameter int DATA_WIDTH   = 24,
    parameter int LOG2_SAMPLES = 7,
    parameter int CHANNELS     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           in_ready,
    input  logic                           bypass,
    output logic                           out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           overrun
);

    localparam int DEPTH     = 1 << LOG2_SAMPLES;
    localparam int MEM_WORDS = CHANNELS * DEPTH;
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ADDR_W    = CH_W + LOG2_SAMPLES;
    localparam int ACC_W     = DATA_WIDTH + LOG2_SAMPLES;
    localparam int FRAME_W   = CHANNELS * DATA_WIDTH;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MEM_WORDS - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_READ   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         clr_cnt_q, clr_cnt_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [LOG2_SAMPLES-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FRAME_W-1:0]        frame_q, frame_d;
    logic                      bypass_q, bypass_d;
    logic signed [ACC_W-1:0]   acc_q [CHANNELS];
    logic signed [ACC_W-1:0]   acc_d [CHANNELS];
    logic                      out_valid_q, out_valid_d;
    logic [FRAME_W-1:0]        out_data_q, out_data_d;
    logic                      overrun_q, overrun_d;

    // History memory (no reset; the CLEAR state zeroes it) and its read register
    logic [DATA_WIDTH-1:0]     hist_mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0]     old_q;
    logic                      mem_we;
    logic                      mem_re;
    logic [ADDR_W-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [ADDR_W-1:0]         hist_addr;
    logic signed [DATA_WIDTH-1:0] new_sample;
    logic signed [DATA_WIDTH-1:0] old_sample;

    // Floor average: the arithmetic shift rounds toward -inf, and the result always fits
    function automatic logic [DATA_WIDTH-1:0] avg_of(input logic signed [ACC_W-1:0] a);
        return DATA_WIDTH'(a >>> LOG2_SAMPLES);
    endfunction

    // Each channel owns a contiguous block of DEPTH words; wr_ptr points at the oldest slot
    assign hist_addr  = {ch_q, wr_ptr_q};
    assign new_sample = frame_q[ch_q*DATA_WIDTH +: DATA_WIDTH];
    assign old_sample = old_q;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;

    // Next-state logic, the shared accumulator update and the history write control
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ch_d        = ch_q;
        wr_ptr_d    = wr_ptr_q;
        frame_d     = frame_q;
        bypass_d    = bypass_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = hist_addr;
        mem_wdata   = new_sample;

        // A frame offered while busy is lost; remember that it happened
        if (in_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    frame_d  = in_data;
                    bypass_d = bypass;
                    ch_d     = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                mem_re  = 1'b1;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                mem_we = 1'b1;
                acc_d[ch_q] = acc_q[ch_q] + ACC_W'(new_sample) - ACC_W'(old_sample);
                if (ch_q == CH_LAST) begin
                    // Load the result as DONE is entered, so data and strobe appear together
                    out_valid_d = 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        out_data_d[c*DATA_WIDTH +: DATA_WIDTH] = bypass_q
                            ? frame_q[c*DATA_WIDTH +: DATA_WIDTH]
                            : avg_of(acc_d[c]);
                    end
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // History memory write port and registered read of the oldest sample
    always_ff @(posedge clk) begin
        if (mem_we) begin
            hist_mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            old_q <= hist_mem[hist_addr];
        end
    end

    // State and datapath registers; reset aborts any frame in flight and restarts CLEAR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            clr_cnt_q   <= '0;
            ch_q        <= '0;
            wr_ptr_q    <= '0;
            frame_q     <= '0;
            bypass_q    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ch_q        <= ch_d;
            wr_ptr_q    <= wr_ptr_d;
            frame_q     <= frame_d;
            bypass_q    <= bypass_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_moving_average_filter_mc.sv
// Bench for moving_average_filter_mc. It uses a window-sum reference model.
module tb_moving_average_filter_mc;

  localparam int DW    = 24;
  localparam int L2    = 7;
  localparam int C     = 2;
  localparam int W     = C * DW;
  localparam int DEPTH = 1 << L2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [W-1:0] in_data;
  logic in_ready;
  logic bypass;
  logic out_valid;
  logic [W-1:0] out_data;
  logic overrun;

  always #5 clk = ~clk;

  moving_average_filter_mc #(.DATA_WIDTH(DW), .LOG2_SAMPLES(L2), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bypass(bypass), .out_valid(out_valid), .out_data(out_data), .overrun(overrun)
  );

  int n_pass = 0;
  int n_checks = 0;

  // reference model: per-channel window of the last DEPTH samples and its exact sum
  logic [W-1:0] exp_q[$];
  longint win [C][DEPTH];
  longint sums [C];
  int head;

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      for (int i = 0; i < DEPTH; i++) win[c][i] = 0;
      sums[c] = 0;
    end
    head = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [W-1:0] frame, input logic byp);
    logic [W-1:0] e;
    logic [DW-1:0] raw;
    longint s, q;
    logic [63:0] qv;
    e = '0;
    for (int c = 0; c < C; c++) begin
      raw = frame[c*DW +: DW];
      s = longint'($signed(raw));
      sums[c] = sums[c] - win[c][head] + s;
      win[c][head] = s;
      q = sums[c] / DEPTH;
      if (sums[c] < 0 && (sums[c] % DEPTH) != 0) q = q - 1;
      qv = q;
      e[c*DW +: DW] = byp ? raw : qv[DW-1:0];
    end
    head = (head + 1) % DEPTH;
    exp_q.push_back(e);
  endtask

  function automatic logic [W-1:0] pack2(input longint a, input longint b);
    logic [63:0] ta, tb;
    ta = a;
    tb = b;
    return {tb[DW-1:0], ta[DW-1:0]};
  endfunction

  function automatic longint rand_sample();
    logic [DW-1:0] r;
    r = DW'($urandom);
    return longint'($signed(r));
  endfunction

  // driver: offer one frame when ready, then watch 10 cycles for the result strobe
  task automatic send_frame(input logic [W-1:0] data, input logic byp,
                            output logic [W-1:0] got, output int lat, output int nv);
    int waited;
    got = '0;
    lat = -1;
    nv = 0;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) return;
    in_valid = 1'b1;
    in_data = data;
    bypass = byp;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = W'({$urandom, $urandom});
    bypass = ~byp;  // must not affect the frame in flight
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        nv++;
        if (lat < 0) begin
          lat = k;
          got = out_data;
        end
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    bypass = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (in_ready === 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== 256) $display("FAIL reset_clear_len: in_ready low for %0d cycles, required 256", cnt);
    else n_pass++;
    n_checks++;
    if (out_data !== '0 || out_valid !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_outputs: out_data %h out_valid %b overrun %b, required all 0", out_data, out_valid, overrun);
    else n_pass++;
  endtask

  task automatic test_step();
    logic [W-1:0] d, got, exp;
    int lat, nv;
    for (int i = 1; i <= 200; i++) begin
      d = pack2(128, -128);
      model_push(d, 1'b0);
      exp = exp_q.pop_front();
      send_frame(d, 1'b0, got, lat, nv);
      n_checks++;
      if (lat !== 5 || nv !== 1) $display("FAIL step[%0d] timing: latency %0d strobes %0d, required 5 and 1", i, lat, nv);
      else n_pass++;
      n_checks++;
      if (got !== exp) $display("FAIL step[%0d] data: got %h required %h", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_impulse();
    logic [W-1:0] d, got, exp;
    int lat, nv;
    // flush the step history with zeros, then one full-scale impulse on ch0
    for (int i = 0; i < 128 + 131; i++) begin
      d = (i == 128) ? pack2(8388607, 0) : pack2(0, 0);
      model_push(d, 1'b0);
      exp = exp_q.pop_front();
      send_frame(d, 1'b0, got, lat, nv);
      n_checks++;
      if (lat !== 5 || got !== exp) $display("FAIL impulse[%0d]: latency %0d got %h required latency 5 data %h", i, lat, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_full_scale();
    logic [W-1:0] d, got, exp;
    int lat, nv;
    for (int i = 0; i < 430; i++) begin
      d = (i < 300) ? pack2(-8388608, 8388607) : pack2(-1, -1);
      model_push(d, 1'b0);
      exp = exp_q.pop_front();
      send_frame(d, 1'b0, got, lat, nv);
      n_checks++;
      if (lat !== 5 || got !== exp) $display("FAIL full_scale[%0d]: latency %0d got %h required latency 5 data %h", i, lat, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] d, got, exp;
    int lat, nv;
    logic byp;
    for (int i = 0; i < 40; i++) begin
      byp = (i < 20);
      d = pack2(rand_sample(), rand_sample());
      model_push(d, byp);
      exp = exp_q.pop_front();
      send_frame(d, byp, got, lat, nv);
      n_checks++;
      if (lat !== 5 || nv !== 1) $display("FAIL bypass[%0d] timing: latency %0d strobes %0d, required 5 and 1", i, lat, nv);
      else n_pass++;
      n_checks++;
      if (got !== exp) $display("FAIL bypass[%0d] data (bypass=%0b): got %h required %h", i, byp, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, got, exp;
    int lat, nv;
    logic byp;
    for (int i = 0; i < 100; i++) begin
      byp = 1'($urandom_range(0, 1));
      d = pack2(rand_sample(), rand_sample());
      model_push(d, byp);
      exp = exp_q.pop_front();
      send_frame(d, byp, got, lat, nv);
      n_checks++;
      if (lat !== 5 || nv !== 1 || got !== exp)
        $display("FAIL random[%0d]: latency %0d strobes %0d got %h required latency 5 strobes 1 data %h", i, lat, nv, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] d, got, exp;
    int lat, nv, waited;
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_pre: got %b required 0", overrun);
    else n_pass++;
    d = pack2(rand_sample(), rand_sample());
    model_push(d, 1'b0);
    exp = exp_q.pop_front();
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b1;
    in_data = d;
    bypass = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // second frame two cycles after the accept: must be dropped
    in_valid = 1'b1;
    in_data = pack2(1000, 1000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    nv = 0;
    got = '0;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        nv++;
        if (lat < 0) begin
          lat = k;
          got = out_data;
        end
      end
    end
    n_checks++;
    if (lat !== 5 || nv !== 1) $display("FAIL overrun_strobes: latency %0d strobes %0d, required 5 and 1", lat, nv);
    else n_pass++;
    n_checks++;
    if (got !== exp) $display("FAIL overrun_data: got %h required %h", got, exp);
    else n_pass++;
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b required 1", overrun);
    else n_pass++;
    d = pack2(rand_sample(), rand_sample());
    model_push(d, 1'b0);
    exp = exp_q.pop_front();
    send_frame(d, 1'b0, got, lat, nv);
    n_checks++;
    if (lat !== 5 || got !== exp) $display("FAIL overrun_next: latency %0d got %h required latency 5 data %h", lat, got, exp);
    else n_pass++;
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b required 1", overrun);
    else n_pass++;
  endtask

  task automatic test_midreset();
    logic [W-1:0] d, got, exp;
    int lat, nv, waited, cnt, n_ov;
    d = pack2(rand_sample(), rand_sample());
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b1;
    in_data = d;
    bypass = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // second cycle after accept: the first channel's UPDATE
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cnt = 0;
    n_ov = 0;
    for (int i = 0; i < 1000; i++) begin
      if (out_valid === 1'b1) n_ov++;
      if (in_ready === 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt !== 256) $display("FAIL midreset_clear_len: in_ready low for %0d cycles, required 256", cnt);
    else n_pass++;
    n_checks++;
    if (n_ov !== 0) $display("FAIL midreset_no_strobe: %0d strobes, required 0", n_ov);
    else n_pass++;
    n_checks++;
    if (out_data !== '0 || overrun !== 1'b0)
      $display("FAIL midreset_outputs: out_data %h overrun %b, required 0 and 0", out_data, overrun);
    else n_pass++;
    // a frame offered during CLEAR is dropped and flags overrun
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    in_valid = 1'b1;
    in_data = pack2(5000, 5000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL clear_overrun: overrun %b in_ready %b, required 1 and 0", overrun, in_ready);
    else n_pass++;
    d = pack2(rand_sample(), rand_sample());
    model_push(d, 1'b0);
    exp = exp_q.pop_front();
    send_frame(d, 1'b0, got, lat, nv);
    n_checks++;
    if (lat !== 5 || got !== exp) $display("FAIL post_reset_frame: latency %0d got %h required latency 5 data %h", lat, got, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_step();
    test_impulse();
    test_full_scale();
    test_bypass();
    test_random();
    test_overrun();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog: the whole run is a few tens of thousands of cycles
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
